instr_fetch_unit: RTL

//  Instruction fetch stage. It is the producer side of the IF/DEC pipeline register.
//  - Owns the PC and issues req/ack reads to instruction memory.
//  - Presents {PC+inc, instruction, valid} to the IF/DEC pipe.
//  - Honours the decode-side stall and redirects on a taken branch.
//  - Absorbs multi-cycle memory latency with a one-entry skid buffer.

---
 rtl/instr_fetch_unit_if.sv | 14 +
 rtl/instr_fetch_unit.sv | 136 +++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory read bus between the fetch unit (master) and the
// instruction memory (slave): level request, one-cycle acknowledge.
interface instr_fetch_unit_if #(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned DATA_WIDTH    = 32
);
    logic                     Mem_Req;
    logic [ADDRESS_WIDTH-1:0] Mem_Addr;
    logic                     Mem_Ack;
    logic [DATA_WIDTH-1:0]    Mem_Data;

    modport master (output Mem_Req, Mem_Addr, input Mem_Ack, Mem_Data);
    modport slave  (input Mem_Req, Mem_Addr, output Mem_Ack, Mem_Data);
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, reads instruction memory over a
// req/ack bus and feeds the IF/DEC register through a one-entry skid buffer.
module instr_fetch_unit #(
    parameter int unsigned              ADDRESS_WIDTH = 32,
    parameter int unsigned              DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0,
    parameter logic [ADDRESS_WIDTH-1:0] PC_INCREMENT  = ADDRESS_WIDTH'(4)
) (
    input  logic                     i_Clk,
    input  logic                     i_Reset,
    input  logic                     i_Stall,
    input  logic                     i_Branch_Taken,
    input  logic [ADDRESS_WIDTH-1:0] i_Branch_Target,
    instr_fetch_unit_if.master       mem_bus,
    output logic                     o_Valid,
    output logic [ADDRESS_WIDTH-1:0] o_PC,
    output logic [DATA_WIDTH-1:0]    o_Instruction
);

    typedef enum logic [1:0] {IDLE, REQ, DROP, FULL} state_t;

    state_t                   state;
    state_t                   state_next;
    logic [ADDRESS_WIDTH-1:0] pc;
    logic [ADDRESS_WIDTH-1:0] pc_next;
    logic [ADDRESS_WIDTH-1:0] mem_addr;
    logic [ADDRESS_WIDTH-1:0] skid_pc;
    logic [DATA_WIDTH-1:0]    skid_instr;
    logic                     mem_req;
    logic                     ack;
    logic                     accept;
    logic                     load_mem;
    logic                     to_skid;
    logic                     start_req;

    // An ack only counts while our request is actually on the bus.
    assign ack       = mem_req && mem_bus.Mem_Ack;
    assign accept    = !o_Valid || !i_Stall;
    assign load_mem  = (state == REQ) && ack && !i_Branch_Taken;
    assign to_skid   = load_mem && !accept;
    assign start_req = (state_next == REQ) && ((state != REQ) || ack);

    assign mem_bus.Mem_Req  = mem_req;
    assign mem_bus.Mem_Addr = mem_addr;

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: state_next = REQ;
            REQ: begin
                if (i_Branch_Taken) begin
                    state_next = ack ? REQ : DROP;
                end else if (to_skid) begin
                    state_next = FULL;
                end
            end
            DROP: begin
                if (ack) begin
                    state_next = REQ;
                end
            end
            FULL: begin
                if (i_Branch_Taken || accept) begin
                    state_next = REQ;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_req = (state == REQ) || (state == DROP);
    end

    // A redirect always wins; otherwise the PC only advances on a useful ack.
    always_comb begin
        pc_next = pc;
        if (i_Branch_Taken) begin
            pc_next = i_Branch_Target;
        end else if ((state == REQ) && ack) begin
            pc_next = pc + PC_INCREMENT;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            pc            <= RESET_PC;
            mem_addr      <= '0;
            o_Valid       <= 1'b0;
            o_PC          <= '0;
            o_Instruction <= '0;
            skid_pc       <= '0;
            skid_instr    <= '0;
        end else begin
            pc <= pc_next;
            if (start_req) begin
                mem_addr <= pc_next;
            end
            if (i_Branch_Taken) begin
                o_Valid       <= 1'b0;
                o_PC          <= '0;
                o_Instruction <= '0;
                skid_pc       <= '0;
                skid_instr    <= '0;
            end else if (to_skid) begin
                skid_pc    <= mem_addr + PC_INCREMENT;
                skid_instr <= mem_bus.Mem_Data;
            end else if (accept) begin
                if (load_mem) begin
                    o_Valid       <= 1'b1;
                    o_PC          <= mem_addr + PC_INCREMENT;
                    o_Instruction <= mem_bus.Mem_Data;
                end else if (state == FULL) begin
                    o_Valid       <= 1'b1;
                    o_PC          <= skid_pc;
                    o_Instruction <= skid_instr;
                    skid_pc       <= '0;
                    skid_instr    <= '0;
                end else begin
                    o_Valid       <= 1'b0;
                    o_PC          <= '0;
                    o_Instruction <= '0;
                end
            end
        end
    end

endmodule
